l15_port_arbiter: RTL and testbench

Shares the single L1.5 transducer request/response port between the fetch stage (requester F) and the memory stage (requester M).
- Grants one header at a time and tracks the single outstanding transaction.
- Routes the response back to its owner.
- Auto-acks non-data returns.
- Publishes arb_eqmem and memOp_done, which the frontend uses to hold the PC while a memory access owns the port.

---
 rtl/l15_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_l15_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l15_port_arbiter.sv
// Shares one L1.5 transducer port between fetch (F) and memory (M).
// Tracks one outstanding transaction and routes acks/returns to its owner.
module l15_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_l15_val,
  input  logic [4:0]  f_l15_rqtype,
  input  logic [2:0]  f_l15_size,
  input  logic [31:0] f_l15_address,
  input  logic [63:0] f_l15_data,
  input  logic        f_l15_req_ack,
  input  logic        m_l15_val,
  input  logic [4:0]  m_l15_rqtype,
  input  logic [2:0]  m_l15_size,
  input  logic [31:0] m_l15_address,
  input  logic [63:0] m_l15_data,
  input  logic        m_l15_req_ack,
  output logic        f_header_ack,
  output logic        f_ack,
  output logic        f_resp_val,
  output logic        m_header_ack,
  output logic        m_ack,
  output logic        m_resp_val,
  output logic        transducer_l15_val,
  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [31:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_req_ack,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  output logic        arb_eqmem,
  output logic        memOp_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  logic             own_m_q, own_m_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             eqmem_q, eqmem_d;
  logic             done_q, done_d;

  logic pick_m, pick_f;
  logic rtn_data, rtn_nd;
  logic own_req_ack;

  assign pick_m = m_l15_val && (!f_l15_val || (starve_q < LIMIT));
  assign pick_f = !pick_m && f_l15_val;

  assign rtn_data = l15_transducer_val &&
                    (l15_transducer_returntype == 4'b0000 ||
                     l15_transducer_returntype == 4'b0001 ||
                     l15_transducer_returntype == 4'b0100);
  assign rtn_nd   = l15_transducer_val && !rtn_data;

  assign own_req_ack = own_m_q ? m_l15_req_ack : f_l15_req_ack;

  always_comb begin
    state_d  = state_q;
    own_m_d  = own_m_q;
    starve_d = starve_q;
    eqmem_d  = eqmem_q;
    done_d   = 1'b0;

    f_header_ack = 1'b0;
    m_header_ack = 1'b0;
    f_ack        = 1'b0;
    m_ack        = 1'b0;
    f_resp_val   = 1'b0;
    m_resp_val   = 1'b0;

    transducer_l15_val     = 1'b0;
    transducer_l15_rqtype  = '0;
    transducer_l15_size    = '0;
    transducer_l15_address = '0;
    transducer_l15_data    = '0;
    transducer_l15_req_ack = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_m) begin
          transducer_l15_val     = 1'b1;
          transducer_l15_rqtype  = m_l15_rqtype;
          transducer_l15_size    = m_l15_size;
          transducer_l15_address = m_l15_address;
          transducer_l15_data    = m_l15_data;
        end else if (pick_f) begin
          transducer_l15_val     = 1'b1;
          transducer_l15_rqtype  = f_l15_rqtype;
          transducer_l15_size    = f_l15_size;
          transducer_l15_address = f_l15_address;
          transducer_l15_data    = f_l15_data;
        end
        m_header_ack = l15_transducer_header_ack && pick_m;
        f_header_ack = l15_transducer_header_ack && pick_f;
        m_ack        = m_header_ack && l15_transducer_ack;
        f_ack        = f_header_ack && l15_transducer_ack;
        if (l15_transducer_header_ack && transducer_l15_val) begin
          own_m_d = pick_m;
          eqmem_d = pick_m;
          state_d = l15_transducer_ack ? RESP : WAIT_ACK;
          if (pick_f)
            starve_d = '0;
          else if (f_l15_val && starve_q != LIMIT)
            starve_d = starve_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        m_ack = l15_transducer_ack && own_m_q;
        f_ack = l15_transducer_ack && !own_m_q;
        if (l15_transducer_ack)
          state_d = RESP;
      end
      RESP: begin
        if (rtn_data) begin
          m_resp_val = own_m_q;
          f_resp_val = !own_m_q;
          transducer_l15_req_ack = own_req_ack;
          if (own_req_ack) begin
            state_d = IDLE;
            eqmem_d = 1'b0;
            done_d  = own_m_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Non-data and stale data returns are swallowed without a state change
    if (rtn_nd) begin
      transducer_l15_req_ack = 1'b1;
      f_resp_val = 1'b1;
    end
    if (rtn_data && state_q != RESP)
      transducer_l15_req_ack = 1'b1;

    if (rst) begin
      f_header_ack = 1'b0;
      m_header_ack = 1'b0;
      f_ack        = 1'b0;
      m_ack        = 1'b0;
      f_resp_val   = 1'b0;
      m_resp_val   = 1'b0;
      transducer_l15_val     = 1'b0;
      transducer_l15_rqtype  = '0;
      transducer_l15_size    = '0;
      transducer_l15_address = '0;
      transducer_l15_data    = '0;
      transducer_l15_req_ack = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      own_m_q  <= 1'b0;
      starve_q <= '0;
      eqmem_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_m_q  <= own_m_d;
      starve_q <= starve_d;
      eqmem_q  <= eqmem_d;
      done_q   <= done_d;
    end
  end

  assign arb_eqmem  = eqmem_q;
  assign memOp_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_l15_port_arbiter.sv
// Randomized self-checking bench for l15_port_arbiter.
// Bench plays both requesters and the L1.5 side.
module tb_l15_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_l15_val, m_l15_val;
  logic [4:0]  f_l15_rqtype, m_l15_rqtype;
  logic [2:0]  f_l15_size, m_l15_size;
  logic [31:0] f_l15_address, m_l15_address;
  logic [63:0] f_l15_data, m_l15_data;
  logic        f_l15_req_ack, m_l15_req_ack;
  logic        f_header_ack, f_ack, f_resp_val;
  logic        m_header_ack, m_ack, m_resp_val;
  logic        transducer_l15_val;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [31:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        transducer_l15_req_ack;
  logic        l15_transducer_header_ack, l15_transducer_ack;
  logic        l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic        arb_eqmem, memOp_done, busy;

  int errors = 0;
  int checks = 0;
  int starve_m = 0;

  always #5 clk = ~clk;

  l15_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .f_l15_val(f_l15_val), .f_l15_rqtype(f_l15_rqtype),
    .f_l15_size(f_l15_size), .f_l15_address(f_l15_address),
    .f_l15_data(f_l15_data), .f_l15_req_ack(f_l15_req_ack),
    .m_l15_val(m_l15_val), .m_l15_rqtype(m_l15_rqtype),
    .m_l15_size(m_l15_size), .m_l15_address(m_l15_address),
    .m_l15_data(m_l15_data), .m_l15_req_ack(m_l15_req_ack),
    .f_header_ack(f_header_ack), .f_ack(f_ack), .f_resp_val(f_resp_val),
    .m_header_ack(m_header_ack), .m_ack(m_ack), .m_resp_val(m_resp_val),
    .transducer_l15_val(transducer_l15_val),
    .transducer_l15_rqtype(transducer_l15_rqtype),
    .transducer_l15_size(transducer_l15_size),
    .transducer_l15_address(transducer_l15_address),
    .transducer_l15_data(transducer_l15_data),
    .transducer_l15_req_ack(transducer_l15_req_ack),
    .l15_transducer_header_ack(l15_transducer_header_ack),
    .l15_transducer_ack(l15_transducer_ack),
    .l15_transducer_val(l15_transducer_val),
    .l15_transducer_returntype(l15_transducer_returntype),
    .arb_eqmem(arb_eqmem), .memOp_done(memOp_done), .busy(busy)
  );

  task automatic clear_inputs();
    f_l15_val = 0; m_l15_val = 0;
    f_l15_rqtype = 0; m_l15_rqtype = 0;
    f_l15_size = 0; m_l15_size = 0;
    f_l15_address = 0; m_l15_address = 0;
    f_l15_data = 0; m_l15_data = 0;
    f_l15_req_ack = 0; m_l15_req_ack = 0;
    l15_transducer_header_ack = 0; l15_transducer_ack = 0;
    l15_transducer_val = 0; l15_transducer_returntype = 0;
  endtask

  function automatic logic [3:0] data_rt();
    int k;
    k = $urandom_range(0, 2);
    return (k == 0) ? 4'b0000 : (k == 1) ? 4'b0001 : 4'b0100;
  endfunction

  // Full transaction: ack_dly = WAIT cycles (ack on last; 0 = ack with header),
  // gap = RESP cycles with no return, hold = data cycles with req_ack low.
  task automatic do_txn(input bit fv, input bit mv,
                        input logic [31:0] fa, input logic [31:0] ma,
                        input int ack_dly, input int gap, input int hold,
                        input bit nd, output bit won_m);
    bit exp_m;
    logic own_ack, oth_ack, own_rv, oth_rv;
    @(negedge clk);
    f_l15_val = fv; m_l15_val = mv;
    f_l15_address = fa; m_l15_address = ma;
    f_l15_rqtype = 5'($urandom); m_l15_rqtype = 5'($urandom);
    f_l15_size = 3'($urandom); m_l15_size = 3'($urandom);
    f_l15_data = 64'd0; m_l15_data = {$urandom, $urandom};
    l15_transducer_header_ack = 1;
    l15_transducer_ack = (ack_dly == 0);
    exp_m = mv && (!fv || starve_m < LIMIT);
    #1;
    won_m = m_header_ack;
    checks++; if (transducer_l15_val !== 1'b1) begin errors++; $display("FAIL grant_tval got=%b exp=1", transducer_l15_val); end
    checks++; if (m_header_ack !== exp_m) begin errors++; $display("FAIL m_header_ack got=%b exp=%b", m_header_ack, exp_m); end
    checks++; if (f_header_ack !== !exp_m) begin errors++; $display("FAIL f_header_ack got=%b exp=%b", f_header_ack, !exp_m); end
    checks++; if (transducer_l15_address !== (exp_m ? ma : fa)) begin errors++; $display("FAIL grant_addr got=%h exp=%h", transducer_l15_address, exp_m ? ma : fa); end
    checks++; if (transducer_l15_data !== (exp_m ? m_l15_data : 64'd0)) begin errors++; $display("FAIL grant_data got=%h exp=%h", transducer_l15_data, exp_m ? m_l15_data : 64'd0); end
    checks++; if (transducer_l15_rqtype !== (exp_m ? m_l15_rqtype : f_l15_rqtype)) begin errors++; $display("FAIL grant_rqtype got=%h", transducer_l15_rqtype); end
    checks++; if (transducer_l15_size !== (exp_m ? m_l15_size : f_l15_size)) begin errors++; $display("FAIL grant_size got=%h", transducer_l15_size); end
    if (ack_dly == 0) begin
      own_ack = exp_m ? m_ack : f_ack;
      checks++; if (own_ack !== 1'b1) begin errors++; $display("FAIL early_ack got=%b exp=1", own_ack); end
    end
    if (exp_m && fv) starve_m = (starve_m < LIMIT) ? starve_m + 1 : LIMIT;
    else if (!exp_m) starve_m = 0;
    @(posedge clk); #1;
    checks++; if (arb_eqmem !== exp_m) begin errors++; $display("FAIL eqmem_grant got=%b exp=%b", arb_eqmem, exp_m); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_grant got=%b exp=1", busy); end
    @(negedge clk);
    if (exp_m) m_l15_val = 0; else f_l15_val = 0;
    l15_transducer_header_ack = 0;
    l15_transducer_ack = 0;
    for (int i = 0; i < ack_dly; i++) begin
      l15_transducer_ack = (i == ack_dly - 1);
      l15_transducer_val = nd && (i == 0);
      l15_transducer_returntype = 4'b0111;
      #1;
      own_ack = exp_m ? m_ack : f_ack;
      oth_ack = exp_m ? f_ack : m_ack;
      checks++; if (transducer_l15_val !== 1'b0) begin errors++; $display("FAIL wait_tval got=%b exp=0", transducer_l15_val); end
      checks++; if (own_ack !== l15_transducer_ack) begin errors++; $display("FAIL wait_own_ack got=%b exp=%b", own_ack, l15_transducer_ack); end
      checks++; if (oth_ack !== 1'b0) begin errors++; $display("FAIL wait_oth_ack got=%b exp=0", oth_ack); end
      checks++; if (transducer_l15_req_ack !== l15_transducer_val) begin errors++; $display("FAIL wait_req_ack got=%b exp=%b", transducer_l15_req_ack, l15_transducer_val); end
      checks++; if (f_resp_val !== l15_transducer_val) begin errors++; $display("FAIL nd_f_resp got=%b exp=%b", f_resp_val, l15_transducer_val); end
      checks++; if (m_resp_val !== 1'b0) begin errors++; $display("FAIL nd_m_resp got=%b exp=0", m_resp_val); end
      @(negedge clk);
    end
    l15_transducer_ack = 0;
    for (int i = 0; i < gap; i++) begin
      l15_transducer_val = 0;
      #1;
      own_rv = exp_m ? m_resp_val : f_resp_val;
      checks++; if (own_rv !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap got=%b/%b exp=0/1", own_rv, busy); end
      @(negedge clk);
    end
    for (int i = 0; i <= hold; i++) begin
      l15_transducer_val = 1;
      l15_transducer_returntype = data_rt();
      if (exp_m) m_l15_req_ack = (i == hold); else f_l15_req_ack = (i == hold);
      #1;
      own_rv = exp_m ? m_resp_val : f_resp_val;
      oth_rv = exp_m ? f_resp_val : m_resp_val;
      checks++; if (own_rv !== 1'b1) begin errors++; $display("FAIL resp_own got=%b exp=1", own_rv); end
      checks++; if (oth_rv !== 1'b0) begin errors++; $display("FAIL resp_oth got=%b exp=0", oth_rv); end
      checks++; if (transducer_l15_req_ack !== (i == hold)) begin errors++; $display("FAIL resp_req_ack got=%b exp=%b", transducer_l15_req_ack, i == hold); end
      checks++; if (busy !== 1'b1 || transducer_l15_val !== 1'b0) begin errors++; $display("FAIL resp_busy got=%b/%b exp=1/0", busy, transducer_l15_val); end
      if (i == hold) begin
        @(posedge clk); #1;
      end else begin
        @(negedge clk);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got=%b exp=0", busy); end
    checks++; if (arb_eqmem !== 1'b0) begin errors++; $display("FAIL done_eqmem got=%b exp=0", arb_eqmem); end
    checks++; if (memOp_done !== exp_m) begin errors++; $display("FAIL memop_pulse got=%b exp=%b", memOp_done, exp_m); end
    @(negedge clk);
    l15_transducer_val = 0;
    f_l15_req_ack = 0; m_l15_req_ack = 0;
    @(posedge clk); #1;
    checks++; if (memOp_done !== 1'b0) begin errors++; $display("FAIL memop_clear got=%b exp=0", memOp_done); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    f_l15_val = 1; m_l15_val = 1;
    m_l15_address = 32'h1234_5678;
    l15_transducer_header_ack = 1;
    l15_transducer_val = 1; l15_transducer_returntype = 4'b0111;
    #1;
    checks++; if (transducer_l15_val !== 1'b0 || transducer_l15_address !== 32'd0) begin errors++; $display("FAIL rst_tx got=%b/%h exp=0/0", transducer_l15_val, transducer_l15_address); end
    checks++; if ({f_header_ack, m_header_ack, f_ack, m_ack, f_resp_val, m_resp_val} !== 6'd0) begin errors++; $display("FAIL rst_acks got=%b exp=0", {f_header_ack, m_header_ack, f_ack, m_ack, f_resp_val, m_resp_val}); end
    checks++; if (transducer_l15_req_ack !== 1'b0) begin errors++; $display("FAIL rst_req_ack got=%b exp=0", transducer_l15_req_ack); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || arb_eqmem !== 1'b0 || memOp_done !== 1'b0) begin errors++; $display("FAIL rst_regs got=%b%b%b exp=000", busy, arb_eqmem, memOp_done); end
    @(negedge clk);
    clear_inputs();
    rst = 0;
    starve_m = 0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_f();
    bit w;
    do_txn(1, 0, 32'h4000_0000, 32'd0, 2, 1, 0, 0, w);
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL single_f_owner got=%b exp=0", w); end
  endtask

  task automatic test_m_priority();
    bit w;
    do_txn(1, 1, 32'h4000_0100, 32'h8000_0010, 1, 0, 0, 0, w);
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL prio_m got=%b exp=1", w); end
    do_txn(1, 0, 32'h4000_0100, 32'd0, 0, 0, 0, 0, w);
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL prio_then_f got=%b exp=0", w); end
  endtask

  task automatic test_starvation();
    bit w;
    for (int i = 0; i < 10; i++) begin
      do_txn(1, 1, 32'h4000_0000 + i, 32'h8000_0000 + i, 0, 0, 0, 0, w);
      checks++; if (w !== (i % 5 != 4)) begin errors++; $display("FAIL starve_order idx=%0d got_m=%b exp_m=%b", i, w, i % 5 != 4); end
    end
  endtask

  task automatic test_nondata();
    bit w;
    do_txn(0, 1, 32'd0, 32'h8000_0040, 2, 0, 0, 1, w);
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL nd_owner got=%b exp=1", w); end
  endtask

  task automatic test_req_ack_hold();
    bit w;
    do_txn(0, 1, 32'd0, 32'h8000_0080, 1, 0, 3, 0, w);
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL hold_owner got=%b exp=1", w); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_l15_val = 1; m_l15_address = 32'h8000_0200;
    l15_transducer_header_ack = 1; l15_transducer_ack = 1;
    #1;
    checks++; if (m_header_ack !== 1'b1) begin errors++; $display("FAIL rmid_grant got=%b exp=1", m_header_ack); end
    @(posedge clk); #1;
    checks++; if (arb_eqmem !== 1'b1) begin errors++; $display("FAIL rmid_eqmem got=%b exp=1", arb_eqmem); end
    @(negedge clk);
    clear_inputs();
    rst = 1;
    l15_transducer_val = 1; m_l15_req_ack = 1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || arb_eqmem !== 1'b0 || memOp_done !== 1'b0) begin errors++; $display("FAIL rmid_regs got=%b%b%b exp=000", busy, arb_eqmem, memOp_done); end
    starve_m = 0;
    @(negedge clk);
    rst = 0; m_l15_req_ack = 0;
    l15_transducer_val = 1; l15_transducer_returntype = 4'b0000;
    #1;
    checks++; if (transducer_l15_req_ack !== 1'b1) begin errors++; $display("FAIL stale_req_ack got=%b exp=1", transducer_l15_req_ack); end
    checks++; if (f_resp_val !== 1'b0 || m_resp_val !== 1'b0) begin errors++; $display("FAIL stale_resp got=%b%b exp=00", f_resp_val, m_resp_val); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || memOp_done !== 1'b0) begin errors++; $display("FAIL stale_state got=%b%b exp=00", busy, memOp_done); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_random();
    bit w, fv, mv;
    for (int n = 0; n < 40; n++) begin
      fv = 1'($urandom);
      mv = 1'($urandom);
      if (!fv && !mv) fv = 1;
      do_txn(fv, mv, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 2), $urandom_range(0, 2),
             1'($urandom), w);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_f();
    test_m_priority();
    test_starvation();
    test_nondata();
    test_req_ack_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
